// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Definitions shared by the serial transmitter and its future receiver
// counterpart:
//   - the frame FSM state encoding
//   - the line levels of the start, stop and idle bits
//   - the default word width and bit period
// -----------------------------------------------------------------------------
package serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } ser_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic IDLE_BIT  = 1'b1;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_BIT_CYCLES = 4;

endpackage : serial_pkg

// File: rtl/bit_timer.sv
// -----------------------------------------------------------------------------
// bit_timer
// Per-bit cycle counter. It counts 0..BIT_CYCLES-1 while enabled and wraps to
// 0 after the terminal count. It is held at 0 while cleared.
// Ports:
//   clk_i      system clock
//   rst_l_i    asynchronous active-low reset
//   en_i       count enable (a frame is in progress)
//   clr_i      force the count to 0
//   tc_o       the current count is the terminal count
//   tc_next_o  the count loaded on the next edge is the terminal count.
//              The caller uses it to build registered outputs that line up
//              with the terminal cycle.
// -----------------------------------------------------------------------------
module bit_timer #(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_l_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_o,
    output logic tc_next_o
);

    localparam logic [7:0] TC_VAL = 8'(BIT_CYCLES - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count: clear, wrap at terminal count, or increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (en_i) begin
            if (cnt_q == TC_VAL) begin
                cnt_d = 8'd0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_l_i) begin
        if (!rst_l_i) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o      = (cnt_q == TC_VAL);
    assign tc_next_o = (cnt_d == TC_VAL);

endmodule : bit_timer

// File: rtl/serial_tx.sv
// -----------------------------------------------------------------------------
// serial_tx
// Asynchronous-style serial transmitter. Each frame is sent in this order:
//   1. a start bit (0)
//   2. DATA_W data bits, LSB first
//   3. an optional even-parity bit
//   4. a stop bit (1)
// Every bit is held for BIT_CYCLES clock cycles.
// Ports:
//   clk_i     system clock
//   rst_l_i   asynchronous active-low reset; aborts any frame at once
//   din_i     parallel word, captured only on an accepted load
//   load_i    transmit request, accepted when ready_o is high
//   ready_o   high while idle (registered)
//   txd_o     serial line, idles high (registered)
//   txd_l_o   complement of txd_o
//   done_o    one-cycle pulse in the last cycle of the stop bit (registered)
// -----------------------------------------------------------------------------
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int BIT_CYCLES = DEF_BIT_CYCLES,
    parameter int PARITY_EN  = 0
) (
    input  logic              clk_i,
    input  logic              rst_l_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              load_i,
    output logic              ready_o,
    output logic              txd_o,
    output logic              txd_l_o,
    output logic              done_o
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    // Even parity: the parity bit makes the total count of ones even
    function automatic logic even_parity(input logic [DATA_W-1:0] data);
        return ^data;
    endfunction

    ser_state_e        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              par_q, par_d;
    logic              txd_q, txd_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              tc_s;
    logic              tc_next_s;
    logic              accept_s;

    bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_bit_timer (
        .clk_i    (clk_i),
        .rst_l_i  (rst_l_i),
        .en_i     (state_q != ST_IDLE),
        .clr_i    (state_q == ST_IDLE),
        .tc_o     (tc_s),
        .tc_next_o(tc_next_s)
    );

    assign accept_s = (state_q == ST_IDLE) && load_i;

    // Next-state, shift register and bit index sequencing
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        par_d   = par_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_START;
                    shift_d = din_i;
                    par_d   = even_parity(din_i);
                    idx_d   = {IDX_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tc_s) begin
                    state_d = ST_DATA;
                    idx_d   = {IDX_W{1'b0}};
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (tc_s) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        // Data goes out of bit 0, so shift the next bit into place
                        idx_d   = idx_q + IDX_W'(1);
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (tc_s) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (tc_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values for the next cycle, derived from next-state values so the
    // registered outputs line up with the state they belong to
    always_comb begin
        txd_d = IDLE_BIT;
        case (state_d)
            ST_IDLE:   txd_d = IDLE_BIT;
            ST_START:  txd_d = START_BIT;
            ST_DATA:   txd_d = shift_d[0];
            ST_PARITY: txd_d = par_d;
            ST_STOP:   txd_d = STOP_BIT;
            default:   txd_d = IDLE_BIT;
        endcase
        ready_d = (state_d == ST_IDLE);
        done_d  = (state_d == ST_STOP) && tc_next_s;
    end

    // State, datapath and output registers
    always_ff @(posedge clk_i or negedge rst_l_i) begin
        if (!rst_l_i) begin
            state_q <= ST_IDLE;
            shift_q <= {DATA_W{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
            par_q   <= 1'b0;
            txd_q   <= IDLE_BIT;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign txd_o   = txd_q;
    assign txd_l_o = ~txd_q;
    assign ready_o = ready_q;
    assign done_o  = done_q;

endmodule : serial_tx
